clock_time_core: RTL and testbench

- Upstream timekeeping stage of the digital clock. It holds HH:MM:SS in BCD and advances it on an internal 1 Hz tick derived from CP_100MHz.
- Two pre-debounced key pulses drive a set-time mode. The selected field blinks while it is being set.
- It encodes the time into eight active-low 7-segment patterns plus a DOT vector. These feed the 8-digit multiplexed display driver directly.

---
 rtl/clock_time_core.sv | 157 +++++++++++++++
 tb/tb_clock_time_core.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/clock_time_core.sv
// HH:MM:SS BCD timekeeper with key-driven set mode, blinking edit field and
// registered active-low 7-segment / decimal-point outputs for an 8-digit display.
module clock_time_core #(
  parameter int CLK_Freq  = 100000000,
  parameter int BLINK_DIV = 25000000
) (
  input  logic       CP_100MHz,
  input  logic       CLR,
  input  logic       KEY_MODE,
  input  logic       KEY_INC,
  output logic [6:0] SEG7,
  output logic [6:0] SEG6,
  output logic [6:0] SEG5,
  output logic [6:0] SEG4,
  output logic [6:0] SEG3,
  output logic [6:0] SEG2,
  output logic [6:0] SEG1,
  output logic [6:0] SEG0,
  output logic [7:0] DOT,
  output logic [1:0] MODE,
  output logic       TICK
);

  localparam int PW = (CLK_Freq > 1) ? $clog2(CLK_Freq) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_HOUR = 2'd1,
    SET_MIN  = 2'd2,
    SET_SEC  = 2'd3
  } mode_t;

  mode_t         state;
  logic [3:0]    hr_t, hr_u, mn_t, mn_u, sc_t, sc_u;
  logic [PW-1:0] presc;
  logic [BW-1:0] blink_cnt;
  logic          hidden;

  logic [7:0] hr_n, mn_n, sc_n;
  logic       mn_wrap, sc_wrap;
  logic       presc_last, blink_last;
  logic       blank_h, blank_m, blank_s;

  function automatic logic [6:0] enc(input logic [3:0] d);
    case (d)
      4'd0:    enc = 7'h40;
      4'd1:    enc = 7'h79;
      4'd2:    enc = 7'h24;
      4'd3:    enc = 7'h30;
      4'd4:    enc = 7'h19;
      4'd5:    enc = 7'h12;
      4'd6:    enc = 7'h02;
      4'd7:    enc = 7'h78;
      4'd8:    enc = 7'h00;
      4'd9:    enc = 7'h10;
      default: enc = SEG_BLANK;
    endcase
  endfunction

  // Two-digit BCD increment that wraps to 00 after {t_max,u_max}.
  function automatic logic [7:0] inc_bcd(input logic [3:0] t, input logic [3:0] u,
                                         input logic [3:0] t_max, input logic [3:0] u_max);
    if (t == t_max && u == u_max) inc_bcd = 8'h00;
    else if (u == 4'd9)           inc_bcd = {t + 4'd1, 4'd0};
    else                          inc_bcd = {t, u + 4'd1};
  endfunction

  always_comb begin
    sc_n       = inc_bcd(sc_t, sc_u, 4'd5, 4'd9);
    mn_n       = inc_bcd(mn_t, mn_u, 4'd5, 4'd9);
    hr_n       = inc_bcd(hr_t, hr_u, 4'd2, 4'd3);
    sc_wrap    = (sc_t == 4'd5) && (sc_u == 4'd9);
    mn_wrap    = (mn_t == 4'd5) && (mn_u == 4'd9);
    presc_last = (presc == PW'(CLK_Freq - 1));
    blink_last = (blink_cnt == BW'(BLINK_DIV - 1));
    blank_h    = hidden && (state == SET_HOUR);
    blank_m    = hidden && (state == SET_MIN);
    blank_s    = hidden && (state == SET_SEC);
  end

  assign MODE = state;

  // KEY_MODE / KEY_INC are single-cycle strobes sampled on the rising edge;
  // there is no back-pressure, and KEY_MODE takes priority when both arrive.
  always_ff @(posedge CP_100MHz) begin
    if (CLR) begin
      state     <= RUN;
      {hr_t, hr_u, mn_t, mn_u, sc_t, sc_u} <= '0;
      presc     <= '0;
      blink_cnt <= '0;
      hidden    <= 1'b0;
      TICK      <= 1'b0;
      SEG7 <= 7'h40; SEG6 <= 7'h40; SEG5 <= SEG_DASH; SEG4 <= 7'h40;
      SEG3 <= 7'h40; SEG2 <= SEG_DASH; SEG1 <= 7'h40; SEG0 <= 7'h40;
      DOT  <= 8'hFF;
    end else begin
      SEG7 <= blank_h ? SEG_BLANK : enc(hr_t);
      SEG6 <= blank_h ? SEG_BLANK : enc(hr_u);
      SEG5 <= SEG_DASH;
      SEG4 <= blank_m ? SEG_BLANK : enc(mn_t);
      SEG3 <= blank_m ? SEG_BLANK : enc(mn_u);
      SEG2 <= SEG_DASH;
      SEG1 <= blank_s ? SEG_BLANK : enc(sc_t);
      SEG0 <= blank_s ? SEG_BLANK : enc(sc_u);
      DOT  <= (state == RUN) ? {3'b111, ~sc_u[0], 4'b1111} : 8'hFE;

      if (state == RUN) begin
        TICK <= presc_last;
        if (presc_last) begin
          presc        <= '0;
          {sc_t, sc_u} <= sc_n;
          if (sc_wrap) begin
            {mn_t, mn_u} <= mn_n;
            if (mn_wrap) {hr_t, hr_u} <= hr_n;
          end
        end else begin
          presc <= presc + PW'(1);
        end
      end else begin
        presc <= '0;
        TICK  <= 1'b0;
      end

      if (KEY_MODE) begin
        case (state)
          RUN:      state <= SET_HOUR;
          SET_HOUR: state <= SET_MIN;
          SET_MIN:  state <= SET_SEC;
          default:  state <= RUN;
        endcase
      end else if (KEY_INC) begin
        case (state)
          SET_HOUR: {hr_t, hr_u} <= hr_n;
          SET_MIN:  {mn_t, mn_u} <= mn_n;
          SET_SEC:  {sc_t, sc_u} <= sc_n;
          default:  ;
        endcase
      end

      // Any key press restarts the blink so the edited field shows at once.
      if (KEY_MODE || KEY_INC) begin
        blink_cnt <= '0;
        hidden    <= 1'b0;
      end else if (blink_last) begin
        blink_cnt <= '0;
        hidden    <= ~hidden;
      end else begin
        blink_cnt <= blink_cnt + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_clock_time_core.sv
// Directed bench for clock_time_core with a fast prescaler (10) and blink divider (4).
module tb_clock_time_core;

  logic       clk;
  logic       CLR, KEY_MODE, KEY_INC;
  logic [6:0] SEG7, SEG6, SEG5, SEG4, SEG3, SEG2, SEG1, SEG0;
  logic [7:0] DOT;
  logic [1:0] MODE;
  logic       TICK;

  int n_cmp = 0;
  int n_err = 0;

  clock_time_core #(.CLK_Freq(10), .BLINK_DIV(4)) dut (
    .CP_100MHz(clk), .CLR(CLR), .KEY_MODE(KEY_MODE), .KEY_INC(KEY_INC),
    .SEG7(SEG7), .SEG6(SEG6), .SEG5(SEG5), .SEG4(SEG4),
    .SEG3(SEG3), .SEG2(SEG2), .SEG1(SEG1), .SEG0(SEG0),
    .DOT(DOT), .MODE(MODE), .TICK(TICK)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       kmode;
    int         reps;
    logic [1:0] exp_mode;
    logic [6:0] exp_hi;
    logic [6:0] exp_lo;
    logic [7:0] exp_dot;
  } vec_t;

  vec_t vecs[19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Called at a falling edge; the strobe is seen by exactly one rising edge.
  task automatic pulse(input logic m, input logic i);
    KEY_MODE = m;
    KEY_INC  = i;
    @(negedge clk);
    KEY_MODE = 1'b0;
    KEY_INC  = 1'b0;
  endtask

  task automatic do_reset();
    CLR = 1'b1;
    @(negedge clk);
    CLR = 1'b0;
  endtask

  task automatic check_zero_display(input string tag);
    check({tag, "_seg7"}, SEG7, 7'h40);
    check({tag, "_seg6"}, SEG6, 7'h40);
    check({tag, "_seg5"}, SEG5, 7'h3F);
    check({tag, "_seg4"}, SEG4, 7'h40);
    check({tag, "_seg3"}, SEG3, 7'h40);
    check({tag, "_seg2"}, SEG2, 7'h3F);
    check({tag, "_seg1"}, SEG1, 7'h40);
    check({tag, "_seg0"}, SEG0, 7'h40);
    check({tag, "_dot"},  DOT,  8'hFF);
    check({tag, "_mode"}, MODE, 2'd0);
  endtask

  initial begin
    CLR = 1'b0; KEY_MODE = 1'b0; KEY_INC = 1'b0;

    // Reset state right after the reset edge and after 3 idle cycles.
    do_reset();
    check_zero_display("rst0");
    check("rst0_tick", TICK, 1'b0);
    repeat (3) @(negedge clk);
    check_zero_display("rst3");
    check("rst3_tick", TICK, 1'b0);

    // Tick cadence and seconds rollover into the display.
    do_reset();
    for (int c = 1; c <= 35; c++) begin
      @(negedge clk);
      check($sformatf("tick_c%0d", c), TICK, (c % 10 == 0) ? 1'b1 : 1'b0);
      if (c == 11) begin
        check("sec1_seg0", SEG0, 7'h79);
        check("sec1_dot", DOT, 8'hEF);
      end
      if (c == 21) begin
        check("sec2_seg0", SEG0, 7'h24);
        check("sec2_dot", DOT, 8'hFF);
      end
      if (c == 30) check("sec2_latency_seg0", SEG0, 7'h24);
      if (c == 31) begin
        check("sec3_seg0", SEG0, 7'h30);
        check("sec3_seg1", SEG1, 7'h40);
      end
    end

    // Set-mode table: kmode=1 -> one KEY_MODE pulse, else reps KEY_INC pulses.
    vecs[0]  = '{1'b1, 1,  2'd1, 7'h40, 7'h40, 8'hFE};
    vecs[1]  = '{1'b0, 1,  2'd1, 7'h40, 7'h79, 8'hFE};
    vecs[2]  = '{1'b0, 1,  2'd1, 7'h40, 7'h24, 8'hFE};
    vecs[3]  = '{1'b0, 7,  2'd1, 7'h40, 7'h10, 8'hFE};
    vecs[4]  = '{1'b0, 1,  2'd1, 7'h79, 7'h40, 8'hFE};
    vecs[5]  = '{1'b0, 9,  2'd1, 7'h79, 7'h10, 8'hFE};
    vecs[6]  = '{1'b0, 4,  2'd1, 7'h24, 7'h30, 8'hFE};
    vecs[7]  = '{1'b0, 1,  2'd1, 7'h40, 7'h40, 8'hFE};
    vecs[8]  = '{1'b0, 23, 2'd1, 7'h24, 7'h30, 8'hFE};
    vecs[9]  = '{1'b1, 1,  2'd2, 7'h40, 7'h40, 8'hFE};
    vecs[10] = '{1'b0, 34, 2'd2, 7'h30, 7'h19, 8'hFE};
    vecs[11] = '{1'b0, 25, 2'd2, 7'h12, 7'h10, 8'hFE};
    vecs[12] = '{1'b0, 1,  2'd2, 7'h40, 7'h40, 8'hFE};
    vecs[13] = '{1'b0, 59, 2'd2, 7'h12, 7'h10, 8'hFE};
    vecs[14] = '{1'b1, 1,  2'd3, 7'h40, 7'h40, 8'hFE};
    vecs[15] = '{1'b0, 46, 2'd3, 7'h19, 7'h02, 8'hFE};
    vecs[16] = '{1'b0, 21, 2'd3, 7'h40, 7'h78, 8'hFE};
    vecs[17] = '{1'b0, 52, 2'd3, 7'h12, 7'h10, 8'hFE};
    vecs[18] = '{1'b1, 1,  2'd0, 7'h12, 7'h10, 8'hEF};

    do_reset();
    for (int i = 0; i < 19; i++) begin
      repeat (vecs[i].reps) pulse(vecs[i].kmode, ~vecs[i].kmode);
      @(negedge clk);
      check($sformatf("vec%0d_mode", i), MODE, vecs[i].exp_mode);
      check($sformatf("vec%0d_dot", i), DOT, vecs[i].exp_dot);
      case (vecs[i].exp_mode)
        2'd1: begin
          check($sformatf("vec%0d_hi", i), SEG7, vecs[i].exp_hi);
          check($sformatf("vec%0d_lo", i), SEG6, vecs[i].exp_lo);
        end
        2'd2: begin
          check($sformatf("vec%0d_hi", i), SEG4, vecs[i].exp_hi);
          check($sformatf("vec%0d_lo", i), SEG3, vecs[i].exp_lo);
        end
        default: begin
          check($sformatf("vec%0d_hi", i), SEG1, vecs[i].exp_hi);
          check($sformatf("vec%0d_lo", i), SEG0, vecs[i].exp_lo);
        end
      endcase
    end

    // 23:59:59 rolls to 00:00:00 on the first tick, 10 cycles after leaving SET_SEC.
    for (int c = 2; c <= 11; c++) begin
      @(negedge clk);
      check($sformatf("wrap_tick_c%0d", c), TICK, (c == 10) ? 1'b1 : 1'b0);
      if (c == 10) begin
        check("pre_wrap_seg7", SEG7, 7'h24);
        check("pre_wrap_seg6", SEG6, 7'h30);
        check("pre_wrap_seg4", SEG4, 7'h12);
        check("pre_wrap_seg3", SEG3, 7'h10);
        check("pre_wrap_seg0", SEG0, 7'h10);
      end
    end
    check_zero_display("wrap");

    // Simultaneous keys in SET_HOUR at 05: mode advances, hour unchanged.
    do_reset();
    pulse(1'b1, 1'b0);
    repeat (5) pulse(1'b0, 1'b1);
    pulse(1'b1, 1'b1);
    @(negedge clk);
    check("simul_mode", MODE, 2'd2);
    check("simul_seg7", SEG7, 7'h40);
    check("simul_seg6", SEG6, 7'h12);

    // Blink in SET_MIN at 03: visible 4 output cycles, hidden 4, and so on.
    repeat (3) pulse(1'b0, 1'b1);
    for (int k = 1; k <= 14; k++) begin
      logic hid;
      @(negedge clk);
      hid = (((k - 1) / 4) % 2) == 1;
      check($sformatf("blink_k%0d_seg4", k), SEG4, hid ? 7'h7F : 7'h40);
      check($sformatf("blink_k%0d_seg3", k), SEG3, hid ? 7'h7F : 7'h30);
      check($sformatf("blink_k%0d_seg7", k), SEG7, 7'h40);
      check($sformatf("blink_k%0d_seg6", k), SEG6, 7'h12);
    end
    check("set_tick_low", TICK, 1'b0);
    pulse(1'b0, 1'b1);
    check("inc_edge_seg3", SEG3, 7'h7F);
    @(negedge clk);
    check("inc_vis_seg4", SEG4, 7'h40);
    check("inc_vis_seg3", SEG3, 7'h19);

    // CLR in the middle of SET_SEC with seconds at 37.
    pulse(1'b1, 1'b0);
    repeat (37) pulse(1'b0, 1'b1);
    @(negedge clk);
    check("sec37_mode", MODE, 2'd3);
    check("sec37_seg1", SEG1, 7'h30);
    check("sec37_seg0", SEG0, 7'h78);
    check("sec37_dot", DOT, 8'hFE);
    do_reset();
    check_zero_display("clr_set");
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      check($sformatf("clr_tick_c%0d", c), TICK, (c == 10) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
